// File: rtl/fetch_arbiter_pkg.sv
// Shared definitions for the instruction-fetch read arbiter: state encoding,
// parameter defaults and a one-hot to index helper.
package fetch_arbiter_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } arb_state_e;

    localparam int NREQ_DEF     = 4;
    localparam int MAX_HOLD_DEF = 8;
    localparam int TIMEOUT_DEF  = 255;

    // Requester counts never exceed 8, so a 3-bit index covers every build.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            idx = idx | (oh[i] ? 3'(i) : 3'd0);
        end
        return idx;
    endfunction

endpackage

// File: rtl/fetch_arbiter_rr_pick.sv
// Combinational round-robin selector: first requesting index after 'last',
// wrapping from NREQ-1 back to 0.
module rr_pick
    import fetch_arbiter_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [NREQ-1:0] pick,
    output logic            valid
);

    logic [IW-1:0] w_idx;
    logic          w_found;

    // Walk the ring starting just after 'last'; the first hit wins.
    always_comb begin
        pick    = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i <= NREQ; i++) begin
            w_idx       = IW'((int'(last) + i) % NREQ);
            pick[w_idx] = pick[w_idx] | (req[w_idx] & ~w_found);
            w_found     = w_found | req[w_idx];
        end
    end

    assign valid = |req;

endmodule

// File: rtl/fetch_arbiter.sv
// Round-robin arbiter multiplexing NREQ read requesters onto one WISHBONE
// read master, with per-grant transaction cap and ack timeout.
module fetch_arbiter
    import fetch_arbiter_pkg::*;
#(
    parameter int NREQ     = NREQ_DEF,
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [32*NREQ-1:0]   req_adr_i,
    input  logic [NREQ-1:0]      req_stb_i,
    output logic [NREQ-1:0]      req_ack_o,
    output logic [31:0]          req_dat_o,
    output logic [31:0]          mwb_adr_o,
    output logic                 mwb_stb_o,
    input  logic                 mwb_ack_i,
    input  logic [31:0]          mwb_dat_i,
    output logic [NREQ-1:0]      grant_o,
    output logic                 timeout_o
);

    localparam int IW = $clog2(NREQ);

    arb_state_e      r_state,   w_state_nxt;
    logic [NREQ-1:0] r_grant,   w_grant_nxt;
    logic [IW-1:0]   r_gidx,    w_gidx_nxt;
    logic [IW-1:0]   r_last,    w_last_nxt;
    logic [7:0]      r_hold,    w_hold_nxt;
    logic [7:0]      r_wait,    w_wait_nxt;
    logic            r_timeout, w_timeout_nxt;

    logic [NREQ-1:0] w_pick;
    logic            w_pick_vld;
    logic [IW-1:0]   w_pick_idx;
    logic [7:0]      w_hold_inc;
    logic            w_busy;
    logic            w_ack;
    logic [31:0]     w_adr [NREQ];

    rr_pick #(.NREQ(NREQ), .IW(IW)) u_rr_pick (
        .req   (req_stb_i),
        .last  (r_last),
        .pick  (w_pick),
        .valid (w_pick_vld)
    );

    assign w_pick_idx = IW'(onehot_to_idx(8'(w_pick)));

    for (genvar k = 0; k < NREQ; k++) begin : g_adr
        assign w_adr[k] = req_adr_i[32*k +: 32];
    end

    assign w_busy     = (r_state == ST_BUSY);
    assign mwb_stb_o  = w_busy & req_stb_i[r_gidx];
    assign mwb_adr_o  = w_busy ? w_adr[r_gidx] : 32'd0;
    // Acks seen during reset or with no strobe outstanding are dropped.
    assign w_ack      = mwb_ack_i & mwb_stb_o & ~rst;
    assign req_ack_o  = r_grant & {NREQ{w_ack}};
    assign req_dat_o  = mwb_dat_i;
    assign grant_o    = r_grant;
    assign timeout_o  = r_timeout;
    assign w_hold_inc = r_hold + 8'd1;

    // Next-state and next-register logic for the IDLE/BUSY controller.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_gidx_nxt    = r_gidx;
        w_last_nxt    = r_last;
        w_hold_nxt    = r_hold;
        w_wait_nxt    = r_wait;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_vld) begin
                    w_state_nxt = ST_BUSY;
                    w_grant_nxt = w_pick;
                    w_gidx_nxt  = w_pick_idx;
                    w_hold_nxt  = 8'd0;
                    w_wait_nxt  = 8'd0;
                end else begin
                    w_grant_nxt = '0;
                end
            end
            ST_BUSY: begin
                if (w_ack) begin
                    w_hold_nxt = w_hold_inc;
                    w_wait_nxt = 8'd0;
                    if (w_hold_inc == 8'(MAX_HOLD)) begin
                        w_state_nxt = ST_IDLE;
                        w_grant_nxt = '0;
                        w_last_nxt  = r_gidx;
                    end else begin
                        w_state_nxt = ST_BUSY;
                    end
                end else if (!mwb_stb_o) begin
                    w_state_nxt = ST_IDLE;
                    w_grant_nxt = '0;
                    w_last_nxt  = r_gidx;
                end else if (r_wait == 8'(TIMEOUT - 1)) begin
                    w_state_nxt   = ST_IDLE;
                    w_grant_nxt   = '0;
                    w_last_nxt    = r_gidx;
                    w_timeout_nxt = 1'b1;
                end else begin
                    w_wait_nxt = r_wait + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_gidx    <= '0;
            r_last    <= IW'(NREQ - 1);
            r_hold    <= 8'd0;
            r_wait    <= 8'd0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_gidx    <= w_gidx_nxt;
            r_last    <= w_last_nxt;
            r_hold    <= w_hold_nxt;
            r_wait    <= w_wait_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_arbiter.sv
// Directed bench for fetch_arbiter: reset, round-robin rotation, hold cap,
// timeout, strobe drop and reset-with-ack scenarios.
module tb_fetch_arbiter;

    logic         clk;
    logic         rst;
    logic [127:0] req_adr_i;
    logic [3:0]   req_stb_i;
    logic [3:0]   req_ack_o;
    logic [31:0]  req_dat_o;
    logic [31:0]  mwb_adr_o;
    logic         mwb_stb_o;
    logic         mwb_ack_i;
    logic [31:0]  mwb_dat_i;
    logic [3:0]   grant_o;
    logic         timeout_o;

    int n_tests;
    int n_fail;

    fetch_arbiter #(.NREQ(4), .MAX_HOLD(8), .TIMEOUT(255)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_adr_i (req_adr_i),
        .req_stb_i (req_stb_i),
        .req_ack_o (req_ack_o),
        .req_dat_o (req_dat_o),
        .mwb_adr_o (mwb_adr_o),
        .mwb_stb_o (mwb_stb_o),
        .mwb_ack_i (mwb_ack_i),
        .mwb_dat_i (mwb_dat_i),
        .grant_o   (grant_o),
        .timeout_o (timeout_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_stb_i = 4'b0000;
        mwb_ack_i = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    function automatic logic [31:0] adr_of(input int k);
        return 32'hA000_0000 + 32'(k) * 32'h0000_0100;
    endfunction

    initial begin
        int cnt;
        n_tests   = 0;
        n_fail    = 0;
        req_adr_i = {adr_of(3), adr_of(2), adr_of(1), adr_of(0)};
        mwb_dat_i = 32'hDEAD_BEEF;
        do_reset();

        // reset state
        chk("rst_grant", 32'(grant_o), 32'h0);
        chk("rst_tmo", 32'(timeout_o), 32'h0);
        chk("rst_stb", 32'(mwb_stb_o), 32'h0);
        chk("rst_adr", mwb_adr_o, 32'h0);
        chk("dat_bcast", req_dat_o, 32'hDEAD_BEEF);

        // single requester, ack every cycle: 8 acks, 1 idle, re-grant
        req_stb_i = 4'b0001;
        mwb_ack_i = 1'b1;
        #1;
        chk("idle_no_ack", 32'(req_ack_o), 32'h0);
        chk("lat_grant0", 32'(grant_o), 32'h0);
        step();
        chk("g0_adr", mwb_adr_o, adr_of(0));
        for (int i = 0; i < 8; i++) begin
            chk("g0_grant", 32'(grant_o), 32'h1);
            chk("g0_ack", 32'(req_ack_o), 32'h1);
            step();
        end
        chk("g0_idle", 32'(grant_o), 32'h0);
        chk("g0_idle_stb", 32'(mwb_stb_o), 32'h0);
        step();
        chk("g0_regrant", 32'(grant_o), 32'h1);

        // all requesting: rotation 0,1,2,3,0 with 8 acks each
        do_reset();
        req_stb_i = 4'b1111;
        mwb_ack_i = 1'b1;
        for (int r = 0; r < 5; r++) begin
            int g;
            g = r % 4;
            chk("rot_idle", 32'(grant_o), 32'h0);
            step();
            chk("rot_adr", mwb_adr_o, adr_of(g));
            for (int i = 0; i < 8; i++) begin
                chk("rot_grant", 32'(grant_o), 32'h1 << g);
                chk("rot_ack", 32'(req_ack_o), 32'h1 << g);
                step();
            end
        end

        // timeout: req 2 granted, slave silent
        do_reset();
        req_stb_i = 4'b1100;
        mwb_ack_i = 1'b0;
        step();
        chk("to_grant2", 32'(grant_o), 32'h4);
        cnt = 0;
        while (grant_o == 4'b0100 && cnt < 300) begin
            if (timeout_o !== 1'b0) begin
                chk("to_early", 32'(timeout_o), 32'h0);
            end
            cnt++;
            step();
        end
        chk("to_cycles", 32'(cnt), 32'd255);
        chk("to_pulse", 32'(timeout_o), 32'h1);
        chk("to_drop", 32'(grant_o), 32'h0);
        step();
        chk("to_pulse_end", 32'(timeout_o), 32'h0);
        chk("to_next3", 32'(grant_o), 32'h8);

        // ack on the timeout-threshold cycle wins
        do_reset();
        req_stb_i = 4'b0100;
        mwb_ack_i = 1'b0;
        step();
        for (int i = 0; i < 254; i++) step();
        chk("thr_still", 32'(grant_o), 32'h4);
        mwb_ack_i = 1'b1;
        #1;
        chk("thr_ack", 32'(req_ack_o), 32'h4);
        step();
        chk("thr_keep", 32'(grant_o), 32'h4);
        chk("thr_no_to", 32'(timeout_o), 32'h0);

        // req 1 granted, 3 acks, then stb drop with stray ack
        do_reset();
        req_stb_i = 4'b0001;
        step();
        req_stb_i = 4'b0000;
        step();
        req_stb_i = 4'b0111;
        step();
        chk("sd_grant1", 32'(grant_o), 32'h2);
        mwb_ack_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("sd_ack", 32'(req_ack_o), 32'h2);
            step();
        end
        req_stb_i = 4'b0101;
        #1;
        chk("sd_stray_ack", 32'(req_ack_o), 32'h0);
        chk("sd_stb_low", 32'(mwb_stb_o), 32'h0);
        step();
        chk("sd_idle", 32'(grant_o), 32'h0);
        chk("sd_hold", 32'(dut.r_hold), 32'd3);
        mwb_ack_i = 1'b0;
        step();
        chk("sd_grant2", 32'(grant_o), 32'h4);

        // reset mid-BUSY with ack high
        req_stb_i = 4'b1111;
        mwb_ack_i = 1'b1;
        step();
        chk("rb_busy", 32'(grant_o), 32'h4);
        rst = 1'b1;
        #1;
        chk("rb_no_ack", 32'(req_ack_o), 32'h0);
        step();
        rst = 1'b0;
        chk("rb_grant0", 32'(grant_o), 32'h0);
        chk("rb_hold0", 32'(dut.r_hold), 32'd0);
        step();
        chk("rb_first0", 32'(grant_o), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
